avalon_mm_read_burst: RTL

AVALON_MM_READ_BURST -- requirements
Module: avalon_mm_read_burst

---
 rtl/avalon_mm_read_burst_pkg.sv | 27 ++
 rtl/avalon_mm_read_burst_sync_fifo.sv | 70 +++++++
 rtl/avalon_mm_read_burst.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/avalon_mm_read_burst_pkg.sv
// Shared types and default constants for the Avalon-MM read burst engine.
// The burst engine and its bench both import this package.
package avalon_mm_read_burst_pkg;

  typedef logic [31:0] triword;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_burst_state_t;

  localparam int DEF_MAX_OUTSTANDING = 4;
  localparam int DEF_FIFO_DEPTH      = 8;
  localparam int DEF_LEN_W           = 8;
  localparam int WORD_BYTES          = 4;

  function automatic triword word_align(input triword a);
    return {a[31:2], 2'b00};
  endfunction

  // Sequential word addresses wrap modulo 2^32.
  function automatic triword next_word(input triword a);
    return a + triword'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/avalon_mm_read_burst_sync_fifo.sv
// Single-clock FIFO used as the response buffer of the read burst engine.
// Pushes when full and pops when empty are dropped so the pointers stay consistent.
module sync_fifo #(
  parameter  int WIDTH = 33,
  parameter  int DEPTH = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push_s, do_pop_s;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      return {AW{1'b0}};
    end else begin
      return p + AW'(1);
    end
  endfunction

  // Next-state pointer and occupancy arithmetic.
  always_comb begin
    do_push_s = push && (cnt_q != CW'(DEPTH));
    do_pop_s  = pop && (cnt_q != {CW{1'b0}});
    wr_ptr_d  = do_push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = do_pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      cnt_q    <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array carries no reset; emptiness is tracked by the count.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = cnt_q;
  assign empty = (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/avalon_mm_read_burst.sv
// Avalon-MM pipelined read burst engine: turns {addr,len} commands into word reads,
// buffers responses under a credit scheme and streams them out with a last flag.
module avalon_mm_read_burst
  import avalon_mm_read_burst_pkg::*;
#(
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
  parameter int LEN_W           = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  triword           cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  output logic [31:0]      address,
  output logic [3:0]       byteenable,
  output logic             read,
  input  logic [31:0]      agent_to_host,
  input  logic             waitrequest,
  input  logic             readdatavalid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rd_burst_state_t  state_q, state_d;
  triword           addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] issued_q, issued_d;
  logic [LEN_W-1:0] recv_q, recv_d;
  logic [OW-1:0]    outst_q, outst_d;
  logic             read_q, read_d;
  logic [3:0]       be_q, be_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             busy_q, busy_d;

  logic             accept_s, resp_s, pop_s, take_s, credit_ok_s;
  logic [31:0]      occ_next_s;
  logic [CW-1:0]    fifo_cnt_s;
  logic             fifo_empty_s;
  logic [32:0]      fifo_din_s, fifo_dout_s;

  // Handshake decode for the Avalon side, the command port and the output stream.
  always_comb begin
    accept_s   = read_q && !waitrequest;
    resp_s     = readdatavalid && (outst_q != {OW{1'b0}});
    pop_s      = !fifo_empty_s && out_ready;
    take_s     = cmd_valid && cmd_ready_q && (state_q == IDLE);
    fifo_din_s = {(recv_q == (len_q - LEN_W'(1))), agent_to_host};
  end

  // Burst control: counters advance on accepts/responses, read is re-armed only within credit.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    addr_d   = accept_s ? next_word(addr_q) : addr_q;
    issued_d = issued_q + LEN_W'(accept_s);
    recv_d   = recv_q + LEN_W'(resp_s);
    outst_d  = outst_q + OW'(accept_s) - OW'(resp_s);
    read_d   = 1'b0;

    // Occupancy seen by a request issued next cycle: in flight plus buffered after this edge.
    occ_next_s  = 32'(outst_d) + 32'(fifo_cnt_s) + 32'(resp_s) - 32'(pop_s);
    credit_ok_s = (occ_next_s < 32'(FIFO_DEPTH)) && (32'(outst_d) < 32'(MAX_OUTSTANDING));

    case (state_q)
      IDLE: begin
        if (take_s && (cmd_len != {LEN_W{1'b0}})) begin
          addr_d   = word_align(cmd_addr);
          len_d    = cmd_len;
          issued_d = {LEN_W{1'b0}};
          recv_d   = {LEN_W{1'b0}};
          read_d   = 1'b1;
          state_d  = ISSUE;
        end else begin
          state_d  = IDLE;
        end
      end
      ISSUE: begin
        if (read_q && waitrequest) begin
          read_d = 1'b1;
        end else begin
          read_d = (issued_d < len_q) && credit_ok_s;
        end
        if (accept_s && (issued_d == len_q)) begin
          state_d = DRAIN;
        end else begin
          state_d = ISSUE;
        end
      end
      DRAIN: begin
        if (pop_s && fifo_dout_s[32] && (outst_q == {OW{1'b0}}) && (fifo_cnt_s == CW'(1))) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    be_d        = read_d ? 4'hF : 4'h0;
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // Control state and registered Avalon/command outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= 32'h0000_0000;
      len_q       <= {LEN_W{1'b0}};
      issued_q    <= {LEN_W{1'b0}};
      recv_q      <= {LEN_W{1'b0}};
      outst_q     <= {OW{1'b0}};
      read_q      <= 1'b0;
      be_q        <= 4'h0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      recv_q      <= recv_d;
      outst_q     <= outst_d;
      read_q      <= read_d;
      be_q        <= be_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  sync_fifo #(
    .WIDTH (33),
    .DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (resp_s),
    .din   (fifo_din_s),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .count (fifo_cnt_s),
    .empty (fifo_empty_s)
  );

  assign address    = addr_q;
  assign byteenable = be_q;
  assign read       = read_q;
  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign out_valid  = !fifo_empty_s;
  assign out_data   = fifo_empty_s ? 32'h0000_0000 : fifo_dout_s[31:0];
  assign out_last   = !fifo_empty_s && fifo_dout_s[32];

endmodule
